// File: rtl/ascon_sbox_pkg.sv
// Shared constants and loader state type for the S-box LUT programming path.
package ascon_sbox_pkg;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 20;
  localparam int unsigned DEPTH  = 32;

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    StIdle,
    StFill,
    StDrain,
    StWaitIdle,
    StCommit
  } loader_state_t;

endpackage

// File: rtl/sbox_shadow_ram.sv
// DEPTH x DATA_W shadow table: one synchronous write port, one combinational read port, no reset.
module sbox_shadow_ram
  import ascon_sbox_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sbox_lut_loader.sv
// Buffers a full S-box table from a valid/ready stream and replays it as one contiguous LUT burst.
// Optional SBOX_LOAD_CHK_EN adds an XOR checksum input that gates the commit.
module sbox_lut_loader
  import ascon_sbox_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [DATA_W-1:0] cfg_data_i,
  input  logic              cfg_last_i,
`ifdef SBOX_LOAD_CHK_EN
  input  logic [DATA_W-1:0] cfg_chk_i,
`endif
  input  logic              perm_busy_i,
  output logic              loading_o,
  output logic              upd_sbox_o,
  output logic [ADDR_W-1:0] sbox_addr_o,
  output logic [DATA_W-1:0] sbox_new_data_o,
  output logic              load_done_o,
  output logic              load_err_o
);

  loader_state_t     state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              loading_q, loading_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              upd_q, upd_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              xfer, shadow_we, chk_ok;
  logic [DATA_W-1:0] shadow_rdata;

  assign cfg_ready_o = (state_q == StIdle) || (state_q == StFill) || (state_q == StDrain);
  assign xfer        = cfg_valid_i && cfg_ready_o;
  assign shadow_we   = xfer && ((state_q == StIdle) || (state_q == StFill));

  // count_q is zero in idle, so it doubles as the write index there and as the replay index later
  sbox_shadow_ram u_shadow (
    .clk   (clk),
    .we    (shadow_we),
    .waddr (count_q[ADDR_W-1:0]),
    .wdata (cfg_data_i),
    .raddr (count_q[ADDR_W-1:0]),
    .rdata (shadow_rdata)
  );

`ifdef SBOX_LOAD_CHK_EN
  logic [DATA_W-1:0] acc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (shadow_we) begin
      acc_q <= (state_q == StIdle) ? cfg_data_i : (acc_q ^ cfg_data_i);
    end
  end

  assign chk_ok = ((acc_q ^ cfg_data_i) == cfg_chk_i);
`else
  assign chk_ok = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    loading_d = loading_q;
    err_d     = err_q;
    done_d    = 1'b0;
    upd_d     = 1'b0;
    addr_d    = '0;
    data_d    = '0;
    case (state_q)
      StIdle: begin
        if (xfer) begin
          if (cfg_last_i) begin
            err_d = 1'b1;
          end else begin
            err_d     = 1'b0;
            loading_d = 1'b1;
            count_d   = CNT_ONE;
            state_d   = StFill;
          end
        end
      end
      StFill: begin
        if (xfer) begin
          count_d = count_q + CNT_ONE;
          if (cfg_last_i) begin
            if ((count_q == CNT_LAST) && chk_ok) begin
              state_d = StWaitIdle;
            end else begin
              err_d     = 1'b1;
              loading_d = 1'b0;
              count_d   = '0;
              state_d   = StIdle;
            end
          end else if (count_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (xfer && cfg_last_i) begin
          loading_d = 1'b0;
          count_d   = '0;
          state_d   = StIdle;
        end
      end
      StWaitIdle: begin
        // count_q wrapped to index 0 in its low bits, so the first entry is already on rdata
        if (!perm_busy_i) begin
          upd_d   = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          data_d  = shadow_rdata;
          count_d = CNT_ONE;
          state_d = StCommit;
        end
      end
      StCommit: begin
        if (count_q == CNT_FULL) begin
          done_d    = 1'b1;
          loading_d = 1'b0;
          count_d   = '0;
          state_d   = StIdle;
        end else begin
          upd_d   = 1'b1;
          addr_d  = count_q[ADDR_W-1:0];
          data_d  = shadow_rdata;
          count_d = count_q + CNT_ONE;
        end
      end
      default: begin
        count_d   = '0;
        loading_d = 1'b0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      count_q   <= '0;
      loading_q <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      upd_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      loading_q <= loading_d;
      err_q     <= err_d;
      done_q    <= done_d;
      upd_q     <= upd_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign loading_o       = loading_q;
  assign upd_sbox_o      = upd_q;
  assign sbox_addr_o     = addr_q;
  assign sbox_new_data_o = data_q;
  assign load_done_o     = done_q;
  assign load_err_o      = err_q;

endmodule

// File: tb/tb_sbox_lut_loader.sv
// Self-checking bench for sbox_lut_loader: vector table, random tables, async reset corner.
module tb_sbox_lut_loader;
  import ascon_sbox_pkg::*;

`ifdef SBOX_LOAD_CHK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid_i, cfg_last_i, perm_busy_i;
  logic [DATA_W-1:0] cfg_data_i, cfg_chk_i;
  logic              cfg_ready_o, loading_o, upd_sbox_o, load_done_o, load_err_o;
  logic [ADDR_W-1:0] sbox_addr_o;
  logic [DATA_W-1:0] sbox_new_data_o;

  sbox_lut_loader dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_valid_i     (cfg_valid_i),
    .cfg_ready_o     (cfg_ready_o),
    .cfg_data_i      (cfg_data_i),
    .cfg_last_i      (cfg_last_i),
`ifdef SBOX_LOAD_CHK_EN
    .cfg_chk_i       (cfg_chk_i),
`endif
    .perm_busy_i     (perm_busy_i),
    .loading_o       (loading_o),
    .upd_sbox_o      (upd_sbox_o),
    .sbox_addr_o     (sbox_addr_o),
    .sbox_new_data_o (sbox_new_data_o),
    .load_done_o     (load_done_o),
    .load_err_o      (load_err_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  typedef struct {
    string tag;
    int    n;
    int    busy;
    bit    gaps;
    bit    bad_chk;
    bit    exp_commit;
  } vec_t;

  wr_t               wr_q[$];
  int                done_q[$];
  logic [DATA_W-1:0] words[$];
  bit                bus_bad;
  int                stuck;
  int                checks = 0;
  int                failures = 0;

  // Observe the LUT bus mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (upd_sbox_o) wr_q.push_back('{cyc, sbox_addr_o, sbox_new_data_o});
    else if (sbox_addr_o != '0 || sbox_new_data_o != '0) bus_bad = 1'b1;
    if (load_done_o) done_q.push_back(cyc);
  end

  task automatic check_eq(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send_table(input int n, input bit gaps, input logic [DATA_W-1:0] base,
                            input bit rnd, input bit bad_chk, output int t_last);
    logic [DATA_W-1:0] x;
    bit acc;
    int tmo;
    x = '0;
    t_last = 0;
    words.delete();
    for (int i = 0; i < n; i++) words.push_back(rnd ? DATA_W'($urandom) : base + DATA_W'(i));
    for (int i = 0; i < n && i < int'(DEPTH); i++) x ^= words[i];
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      cfg_valid_i = 1'b1;
      cfg_data_i  = words[i];
      cfg_last_i  = (i == n - 1);
      cfg_chk_i   = bad_chk ? (x ^ DATA_W'(1)) : x;
      tmo = 0;
      do begin
        @(negedge clk);
        acc = cfg_ready_o;
        if (acc && cfg_last_i) t_last = cyc;
        if (acc && i == int'(DEPTH)) check_eq("err_at_word31", int'(load_err_o), 1);
        @(posedge clk);
        #1;
        tmo++;
      end while (!acc && tmo < 100);
      if (!acc) stuck++;
      cfg_valid_i = 1'b0;
      cfg_last_i  = 1'b0;
    end
  endtask

  task automatic run_table(input string tag, input int n, input int busy, input bit gaps,
                           input bit rnd, input bit bad_chk, input bit exp_commit);
    int t_last, drop, first, nbad;
    wr_q.delete();
    done_q.delete();
    bus_bad = 1'b0;
    stuck = 0;
    perm_busy_i = (busy > 0);
    send_table(n, gaps, 20'hA5A00, rnd, bad_chk, t_last);
    drop = 0;
    if (busy > 0) begin
      repeat (busy) @(posedge clk);
      @(negedge clk);
      check_eq({tag, "_loading_busy"}, int'(loading_o), int'(exp_commit));
      check_eq({tag, "_nowrite_busy"}, wr_q.size(), 0);
      @(posedge clk);
      #1;
      perm_busy_i = 1'b0;
      drop = cyc;
    end
    first = ((t_last + 1 > drop) ? t_last + 1 : drop) + 1;
    repeat (40) @(posedge clk);
    #1;
    check_eq({tag, "_accepted"}, stuck, 0);
    check_eq({tag, "_nwrites"}, wr_q.size(), exp_commit ? int'(DEPTH) : 0);
    if (exp_commit) begin
      nbad = 0;
      foreach (wr_q[i]) begin
        if (i >= n || int'(wr_q[i].addr) != i || wr_q[i].data != words[i] ||
            wr_q[i].cyc != first + i) nbad++;
      end
      check_eq({tag, "_burst"}, nbad, 0);
      check_eq({tag, "_done_cyc"}, (done_q.size() == 1) ? done_q[0] : -1, first + int'(DEPTH));
    end else begin
      check_eq({tag, "_ndone"}, done_q.size(), 0);
    end
    check_eq({tag, "_err"}, int'(load_err_o), int'(!exp_commit));
    check_eq({tag, "_ready"}, int'(cfg_ready_o), 1);
    check_eq({tag, "_loading"}, int'(loading_o), 0);
    check_eq({tag, "_idle_bus"}, int'(bus_bad), 0);
  endtask

  vec_t vecs[8];
  int   rn, rbusy;
  bit   rgaps, rbad;

  initial begin
    rst = 1'b1;
    cfg_valid_i = 1'b0;
    cfg_last_i  = 1'b0;
    cfg_data_i  = '0;
    cfg_chk_i   = '0;
    perm_busy_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", int'(cfg_ready_o), 1);
    check_eq("rst_loading", int'(loading_o), 0);
    check_eq("rst_upd", int'(upd_sbox_o), 0);
    check_eq("rst_addr", int'(sbox_addr_o), 0);
    check_eq("rst_data", int'(sbox_new_data_o), 0);
    check_eq("rst_done", int'(load_done_o), 0);
    check_eq("rst_err", int'(load_err_o), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    vecs[0] = '{"basic", 32, 0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{"busy10", 32, 10, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{"short6", 6, 0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{"reload", 32, 0, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{"long40", 40, 0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{"gaps", 32, 0, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{"first_last", 1, 0, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{"chk_bad", 32, 0, 1'b0, 1'b1, !CHK_EN};
    foreach (vecs[i])
      run_table(vecs[i].tag, vecs[i].n, vecs[i].busy, vecs[i].gaps, 1'b0, vecs[i].bad_chk,
                vecs[i].exp_commit);

    // Random tables: a table commits only if exactly DEPTH words end on the last marker
    for (int r = 0; r < 8; r++) begin
      rn    = ($urandom_range(0, 1) == 1) ? int'(DEPTH) : int'($urandom_range(1, 40));
      rbusy = int'($urandom_range(0, 4));
      rgaps = 1'($urandom_range(0, 1));
      rbad  = 1'($urandom_range(0, 1));
      run_table($sformatf("rnd%0d", r), rn, rbusy, rgaps, 1'b1, rbad,
                (rn == int'(DEPTH)) && !(CHK_EN && rbad));
    end

    // Asynchronous reset in the middle of a fill
    for (int i = 0; i < 5; i++) begin
      cfg_valid_i = 1'b1;
      cfg_data_i  = DATA_W'(i);
      @(posedge clk);
      #1;
    end
    check_eq("fill_loading", int'(loading_o), 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_loading", int'(loading_o), 0);
    check_eq("async_ready", int'(cfg_ready_o), 1);
    check_eq("async_err", int'(load_err_o), 0);
    check_eq("async_upd", int'(upd_sbox_o), 0);
    cfg_valid_i = 1'b0;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_table("post_rst", 32, 2, 1'b1, 1'b1, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
